dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 256: number of 32-bit words in the array.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted per access (0..15).
REQ-004 Port clock, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port req_valid, input, 1: datapath presents an access.
REQ-007 Port req_ready, output, 1: responder can accept an access.
REQ-008 Port req_we, input, 1: 1 = store, 0 = load.
REQ-009 Port req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved (treated as error).
REQ-010 Port req_unsigned, input, 1: 1 = zero-extend load, 0 = sign-extend load.
REQ-011 Port req_addr, input, 32: byte address (the datapath alu_out).
REQ-012 Port req_wd, input, 32: store data, right-aligned (the datapath dmem_wd).
REQ-013 Port rsp_valid, output, 1: one-cycle pulse that completes the access.
REQ-014 Port rsp_rd, output, 32: extended load data, valid with rsp_valid.
REQ-015 Port rsp_err, output, 1: access faulted, valid with rsp_valid.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESPOND.
REQ-017 req_ready SHALL be 1 only in IDLE; an access SHALL be accepted on a cycle where req_valid and req_ready are both 1.
REQ-018 On accept, the FSM SHALL latch req_we, req_size, req_unsigned, req_addr and req_wd, and SHALL ignore request inputs until it returns to IDLE.
REQ-019 From IDLE on accept, the FSM SHALL go to WAIT when WAIT_CYCLES>0, otherwise to RESPOND.
REQ-020 In WAIT, a 4-bit counter SHALL count WAIT_CYCLES cycles, then the FSM SHALL go to RESPOND.
REQ-021 Latency SHALL be WAIT_CYCLES+1 cycles from accept to rsp_valid.
REQ-022 RESPOND SHALL last one cycle, assert rsp_valid, and return to IDLE; back-to-back accepts SHALL have at least one IDLE cycle between them.
REQ-023 A store SHALL be committed to the array on the RESPOND cycle.
REQ-024 A store SHALL write only the addressed byte lanes: byte lane addr[1:0], half lanes {addr[1],0}/{addr[1],1}, word all four lanes.
REQ-025 A load SHALL extract the addressed lane(s) and sign- or zero-extend them per the latched req_unsigned; for stores, rsp_rd SHALL be 0.
REQ-026 The word index SHALL be addr[31:2]; an index >= DEPTH or req_size=11 SHALL set rsp_err=1 with no write and rsp_rd=0.
REQ-027 rsp_rd and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE, the counter SHALL clear, rsp_valid/rsp_rd/rsp_err SHALL be 0, and req_ready SHALL be 1 on the cycle after reset.
REQ-029 Reset during WAIT or RESPOND SHALL abandon the access: no write and no rsp_valid.
REQ-030 Reset SHALL NOT clear the memory array.

Configuration
REQ-031 With DMEM_ALIGN_CHECK_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL set rsp_err=1 with no write and rsp_rd=0.
REQ-032 Without DMEM_ALIGN_CHECK_EN, misaligned low address bits SHALL be forced to zero for the access size and the access SHALL complete normally; range and size errors (REQ-026) SHALL still apply.

Structure
REQ-033 Package dmem_pkg SHALL hold the access-size enum, the FSM state enum, and the constants SIZE_BYTE, SIZE_HALF, SIZE_WORD.
REQ-034 The combinational byte-enable/store-lane generation and load extract/extend logic SHALL live in a sub-module dmem_lane_align.

Verification
REQ-035 Scenario, word round trip: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rd=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 cycles after each accept (default WAIT_CYCLES=2).
REQ-036 Scenario, byte store and signed load: store byte 0x80 at 0x13 over word 0x00000000 -> word reads 0x80000000; signed byte load at 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-037 Scenario, misaligned half load at 0x21: with DMEM_ALIGN_CHECK_EN -> rsp_err=1, rsp_rd=0; without it -> data from 0x20.
REQ-038 Scenario, out of range: store to byte address 4*DEPTH -> rsp_err=1, and array contents are unchanged on readback.
REQ-039 Scenario, reset mid-access: reset asserted in WAIT of a store of 0x12345678 to 0x40 -> no rsp_valid, req_ready=1 after reset, and a later load at 0x40 returns the old value.
REQ-040 Scenario, WAIT_CYCLES=0 with req_valid held high: rsp_valid one cycle after each accept, accepts every 2 cycles, and req_wd changed mid-access does not affect the stored value.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types for the data-memory responder slice.
//   size_t  : access size encoding carried on req_size
//             (SIZE_BYTE / SIZE_HALF / SIZE_WORD; SIZE_RSVD faults)
//   state_t : responder FSM states (IDLE, WAIT, RESPOND)
//   ext_byte / ext_half : sign- or zero-extension helpers for loads
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_RESPOND = 2'b10
  } state_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zero_ext);
    return zero_ext ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zero_ext);
    return zero_ext ? {16'h0, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align -- combinational lane steering for one memory word.
//   size          : access size
//   load_unsigned : 1 = zero-extend load data, 0 = sign-extend
//   addr_lo       : byte address bits [1:0]
//   store_data    : right-aligned store data
//   mem_word      : current contents of the addressed word
//   byte_en       : lanes written by a store
//   store_word    : store data replicated onto the lanes
//   load_data     : extracted and extended load data
//   misaligned    : half with addr_lo[0]=1 or word with addr_lo!=0
// Low address bits below the access size are ignored here, so a
// misaligned access always lands on the naturally aligned lanes; the
// caller decides whether misalignment is a fault.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       size,
  input  logic        load_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h0;
    case (addr_lo)
      2'd0:    sel_byte = mem_word[7:0];
      2'd1:    sel_byte = mem_word[15:8];
      2'd2:    sel_byte = mem_word[23:16];
      default: sel_byte = mem_word[31:24];
    endcase
    sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
  end

  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0;
    load_data  = 32'h0;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
        load_data  = ext_byte(sel_byte, load_unsigned);
      end
      SIZE_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_data  = ext_half(sel_half, load_unsigned);
        misaligned = addr_lo[0];
      end
      SIZE_WORD: begin
        byte_en    = 4'b1111;
        store_word = store_data;
        load_data  = mem_word;
        misaligned = |addr_lo;
      end
      default: begin
        byte_en    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- multi-cycle data memory with wait states.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (see below)
//   req_we, req_size, req_unsigned, req_addr, req_wd : access fields
//   rsp_valid     : one-cycle completion pulse
//   rsp_rd        : extended load data (0 for stores, faults, idle)
//   rsp_err       : access faulted (0 when rsp_valid=0)
//   dbg_state     : current FSM state, for observation only
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned
// half/word accesses; otherwise they are force-aligned and complete.
//
// Handshake: an access is accepted on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, so request inputs
// are ignored from accept until the FSM is back in IDLE. rsp_valid
// pulses WAIT_CYCLES+1 cycles after the accept cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  size_t       lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;

  logic [IDX_W-1:0] idx;
  logic        in_range;
  logic        align_err;
  logic        acc_err;
  logic        respond;
  logic        do_write;
  logic [31:0] mem_word;
  logic [3:0]  byte_en;
  logic [31:0] store_word;
  logic [31:0] load_data;
  logic        misaligned;

  assign req_ready = (state == ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      lat_we       <= 1'b0;
      lat_size     <= SIZE_BYTE;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wd       <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= size_t'(req_size);
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wd       <= req_wd;
            wait_cnt     <= 4'd0;
            state        <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESPOND;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 4'd0;
            state    <= ST_RESPOND;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Upper index bits are dropped for addressing, so the range check must
  // look at the full word index to stop out-of-range stores aliasing.
  assign idx      = lat_addr[IDX_W+1:2];
  assign in_range = ({2'b00, lat_addr[31:2]} < 32'(DEPTH));
  assign mem_word = mem[idx];

  dmem_lane_align u_lane_align (
    .size          (lat_size),
    .load_unsigned (lat_unsigned),
    .addr_lo       (lat_addr[1:0]),
    .store_data    (lat_wd),
    .mem_word      (mem_word),
    .byte_en       (byte_en),
    .store_word    (store_word),
    .load_data     (load_data),
    .misaligned    (misaligned)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = misaligned;
`else
  assign align_err = 1'b0;
`endif

  assign acc_err = !in_range || (lat_size == SIZE_RSVD) || align_err;

  // A reset arriving in the RESPOND cycle abandons the access entirely.
  assign respond  = (state == ST_RESPOND) && !reset;
  assign do_write = respond && lat_we && !acc_err;

  assign rsp_valid = respond;
  assign rsp_err   = respond && acc_err;
  assign rsp_rd    = (respond && !lat_we && !acc_err) ? load_data : 32'h0;

  // The array has no reset: contents survive a reset of the FSM.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][i*8 +: 8] <= store_word[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clock;
  logic        reset;
  logic        a_valid, b_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wd;

  logic        a_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rd;
  logic [1:0]  a_dbg_state;
  logic        b_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rd;
  logic [1:0]  b_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Default configuration: DEPTH=256, WAIT_CYCLES=2.
  dmem_responder u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wd(req_wd),
    .rsp_valid(a_rsp_valid), .rsp_rd(a_rsp_rd), .rsp_err(a_rsp_err),
    .dbg_state(a_dbg_state)
  );

  // Zero-wait-state configuration.
  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wd(req_wd),
    .rsp_valid(b_rsp_valid), .rsp_rd(b_rsp_rd), .rsp_err(b_rsp_err),
    .dbg_state(b_dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: one access on DUT a (sel=0) or b (sel=1). lat counts cycles
  // from the accept cycle to the rsp_valid cycle (capped on timeout).
  task automatic access(input logic sel, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
    int n;
    @(negedge clock);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wd = wd;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    n = 0;
    while (!(sel ? b_ready : a_ready) && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0;
    req_wd = ~wd; req_addr = 32'h3C; req_unsigned = ~uns;
    lat = 1;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    rd  = sel ? b_rsp_rd : a_rsp_rd;
    err = sel ? b_rsp_err : a_rsp_err;
    @(negedge clock);
    check("pulse_end", {31'h0, sel ? b_rsp_valid : a_rsp_valid}, 32'h0);
    check("idle_rd_zero", sel ? b_rsp_rd : a_rsp_rd, 32'h0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  logic        seen;
  logic [31:0] pat [4];

  initial begin
    a_valid = 0; b_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wd = 0;
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;

    // Reset state
    check("rst_ready", {31'h0, a_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    check("rst_rsp_rd", a_rsp_rd, 32'h0);
    check("rst_rsp_err", {31'h0, a_rsp_err}, 32'h0);
    check("rst_state", {30'h0, a_dbg_state}, {30'h0, ST_IDLE});

    // Word round trip
    access(0, 1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, rd, err, lat);
    check("st_word_lat", lat, 3);
    check("st_word_err", {31'h0, err}, 32'h0);
    check("st_word_rd", rd, 32'h0);
    access(0, 0, SIZE_WORD, 0, 32'h10, 32'h0, rd, err, lat);
    check("ld_word_lat", lat, 3);
    check("ld_word_rd", rd, 32'hDEADBEEF);
    check("ld_word_err", {31'h0, err}, 32'h0);

    // Byte store over zero word, signed/unsigned byte loads
    access(0, 1, SIZE_WORD, 0, 32'h10, 32'h00000000, rd, err, lat);
    access(0, 1, SIZE_BYTE, 0, 32'h13, 32'h12345680, rd, err, lat);
    access(0, 0, SIZE_WORD, 0, 32'h10, 32'h0, rd, err, lat);
    check("byte_word_rd", rd, 32'h80000000);
    access(0, 0, SIZE_BYTE, 0, 32'h13, 32'h0, rd, err, lat);
    check("ld_byte_s", rd, 32'hFFFFFF80);
    access(0, 0, SIZE_BYTE, 1, 32'h13, 32'h0, rd, err, lat);
    check("ld_byte_u", rd, 32'h00000080);
    access(0, 0, SIZE_BYTE, 0, 32'h12, 32'h0, rd, err, lat);
    check("ld_byte_s_zero", rd, 32'h00000000);

    // Half lanes
    access(0, 1, SIZE_WORD, 0, 32'h20, 32'h11223344, rd, err, lat);
    access(0, 0, SIZE_HALF, 0, 32'h22, 32'h0, rd, err, lat);
    check("ld_half_hi", rd, 32'h00001122);
    access(0, 1, SIZE_HALF, 0, 32'h22, 32'hFFFF8001, rd, err, lat);
    access(0, 0, SIZE_WORD, 0, 32'h20, 32'h0, rd, err, lat);
    check("half_word_rd", rd, 32'h80013344);
    access(0, 0, SIZE_HALF, 0, 32'h22, 32'h0, rd, err, lat);
    check("ld_half_s", rd, 32'hFFFF8001);
    access(0, 0, SIZE_HALF, 1, 32'h22, 32'h0, rd, err, lat);
    check("ld_half_u", rd, 32'h00008001);

    // Misaligned accesses
    access(0, 0, SIZE_HALF, 0, 32'h21, 32'h0, rd, err, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misal_half_err", {31'h0, err}, 32'h1);
    check("misal_half_rd", rd, 32'h0);
`else
    check("misal_half_err", {31'h0, err}, 32'h0);
    check("misal_half_rd", rd, 32'h00003344);
`endif
    access(0, 0, SIZE_WORD, 0, 32'h23, 32'h0, rd, err, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misal_word_err", {31'h0, err}, 32'h1);
    check("misal_word_rd", rd, 32'h0);
`else
    check("misal_word_err", {31'h0, err}, 32'h0);
    check("misal_word_rd", rd, 32'h80013344);
`endif

    // Reserved size faults
    access(0, 0, SIZE_RSVD, 0, 32'h20, 32'h0, rd, err, lat);
    check("rsvd_err", {31'h0, err}, 32'h1);
    check("rsvd_rd", rd, 32'h0);
    check("rsvd_lat", lat, 3);

    // Out of range: 4*DEPTH would alias to word 0 if the range check failed
    access(0, 1, SIZE_WORD, 0, 32'h0, 32'h0BADF00D, rd, err, lat);
    access(0, 1, SIZE_WORD, 0, 32'h400, 32'hCAFEF00D, rd, err, lat);
    check("oor_st_err", {31'h0, err}, 32'h1);
    access(0, 0, SIZE_WORD, 0, 32'h400, 32'h0, rd, err, lat);
    check("oor_ld_err", {31'h0, err}, 32'h1);
    check("oor_ld_rd", rd, 32'h0);
    access(0, 0, SIZE_WORD, 0, 32'h0, 32'h0, rd, err, lat);
    check("oor_unchanged", rd, 32'h0BADF00D);
    check("oor_readback_err", {31'h0, err}, 32'h0);

    // Reset during WAIT abandons the store
    access(0, 1, SIZE_WORD, 0, 32'h40, 32'hA0A0A0A0, rd, err, lat);
    @(negedge clock);
    req_we = 1; req_size = SIZE_WORD; req_addr = 32'h40; req_wd = 32'h12345678; a_valid = 1;
    @(negedge clock);
    a_valid = 0;
    check("rw_in_wait", {30'h0, a_dbg_state}, {30'h0, ST_WAIT});
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("rw_ready", {31'h0, a_ready}, 32'h1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | a_rsp_valid;
      @(negedge clock);
    end
    check("rw_no_rsp", {31'h0, seen}, 32'h0);
    access(0, 0, SIZE_WORD, 0, 32'h40, 32'h0, rd, err, lat);
    check("rw_old_value", rd, 32'hA0A0A0A0);

    // Reset during RESPOND suppresses the pulse and the write
    access(0, 1, SIZE_WORD, 0, 32'h44, 32'h0F0F0F0F, rd, err, lat);
    @(negedge clock);
    req_we = 1; req_size = SIZE_WORD; req_addr = 32'h44; req_wd = 32'h87654321; a_valid = 1;
    @(negedge clock);
    a_valid = 0;
    @(negedge clock);
    @(negedge clock);
    check("rr_in_respond", {30'h0, a_dbg_state}, {30'h0, ST_RESPOND});
    reset = 1;
    #1;
    check("rr_no_rsp", {31'h0, a_rsp_valid}, 32'h0);
    @(negedge clock);
    reset = 0;
    check("rr_ready", {31'h0, a_ready}, 32'h1);
    access(0, 0, SIZE_WORD, 0, 32'h44, 32'h0, rd, err, lat);
    check("rr_old_value", rd, 32'h0F0F0F0F);

    // WAIT_CYCLES=0 with req_valid held high
    pat[0] = 32'h11111111; pat[1] = 32'h22222222; pat[2] = 32'h33333333; pat[3] = 32'h44444444;
    @(negedge clock);
    req_we = 1; req_size = SIZE_WORD; req_unsigned = 0; b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(4 * i); req_wd = pat[i];
      check("b_ready_idle", {31'h0, b_ready}, 32'h1);
      check("b_no_rsp_idle", {31'h0, b_rsp_valid}, 32'h0);
      @(negedge clock);
      check("b_rsp_next", {31'h0, b_rsp_valid}, 32'h1);
      check("b_busy", {31'h0, b_ready}, 32'h0);
      req_wd = ~pat[i]; req_addr = 32'h3C;
      @(negedge clock);
    end
    b_valid = 0;
    for (int i = 0; i < 4; i++) begin
      access(1, 0, SIZE_WORD, 0, 32'(4 * i), 32'h0, rd, err, lat);
      check("b_ld_lat", lat, 1);
      check("b_ld_rd", rd, pat[i]);
    end
    access(1, 0, SIZE_WORD, 0, 32'h3C, 32'h0, rd, err, lat);
    check("b_junk_unwritten_err", {31'h0, err}, 32'h0);
    access(1, 0, SIZE_WORD, 0, 32'h40, 32'h0, rd, err, lat);
    check("b_oor_err", {31'h0, err}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
